// File: rtl/master_port.sv
// Initiator end of the bit-serial system bus: one parallel request becomes a serial
// transaction (address then write data out on wr_bus, or read data in from rd_bus).
module master_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  rd_bus,
  input  logic                  slave_ready,
  input  logic                  slave_valid
);

  localparam int MAX_AD  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int MAX_ALL = (MAX_AD > TIMEOUT) ? MAX_AD : TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] ADDR_LAST   = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST   = CW'(DATA_WIDTH - 1);
  // The acceptance cycle counts as the first waited cycle, so the abort lands
  // TIMEOUT cycles after the last bus activity.
  localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_RWAIT, S_RECV, S_RSP
  } state_e;

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   addr_sr_q, addr_sr_d;
  logic [DATA_WIDTH-1:0]   data_sr_q, data_sr_d;
  logic [DATA_WIDTH-1:0]   rd_sr_q, rd_sr_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]           stall_cnt_q, stall_cnt_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    stalled;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    addr_sr_d    = addr_sr_q;
    data_sr_d    = data_sr_q;
    rd_sr_d      = rd_sr_q;
    bit_cnt_d    = bit_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    stalled      = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mode         = 1'b0;
    wr_bus       = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          mode_d      = req_mode;
          addr_sr_d   = req_addr;
          data_sr_d   = req_mode ? req_wdata : '0;
          rd_sr_d     = '0;
          bit_cnt_d   = '0;
          stall_cnt_d = '0;
          state_d     = S_ADDR;
        end
      end

      S_ADDR: begin
        master_valid = 1'b1;
        mode         = mode_q;
        wr_bus       = addr_sr_q[ADDR_WIDTH-1];
        if (slave_ready) begin
          addr_sr_d   = addr_sr_q << 1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          stall_cnt_d = '0;
          if (bit_cnt_q == ADDR_LAST) begin
            bit_cnt_d = '0;
            state_d   = mode_q ? S_DATA : S_RWAIT;
          end
        end else begin
          stalled = 1'b1;
        end
      end

      S_DATA: begin
        master_valid = 1'b1;
        mode         = mode_q;
        wr_bus       = data_sr_q[DATA_WIDTH-1];
        if (slave_ready) begin
          data_sr_d   = data_sr_q << 1;
          bit_cnt_d   = bit_cnt_q + 1'b1;
          stall_cnt_d = '0;
          if (bit_cnt_q == DATA_LAST) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
            state_d     = S_RSP;
          end
        end else begin
          stalled = 1'b1;
        end
      end

      S_RWAIT, S_RECV: begin
        master_ready = 1'b1;
        if (slave_valid) begin
          rd_sr_d     = (rd_sr_q << 1) | DATA_WIDTH'(rd_bus);
          bit_cnt_d   = bit_cnt_q + 1'b1;
          stall_cnt_d = '0;
          if (bit_cnt_q == DATA_LAST) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = rd_sr_d;
            state_d     = S_RSP;
          end else begin
            state_d = S_RECV;
          end
        end else begin
          stalled = 1'b1;
        end
      end

      S_RSP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (stalled) begin
      if (stall_cnt_q == STALL_LIMIT) begin
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
        state_d     = S_RSP;
      end else begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      addr_sr_q   <= '0;
      data_sr_q   <= '0;
      rd_sr_q     <= '0;
      bit_cnt_q   <= '0;
      stall_cnt_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_sr_q   <= addr_sr_d;
      data_sr_q   <= data_sr_d;
      rd_sr_q     <= rd_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: a bench-side slave model drives the serial bus and a
// scoreboard queue holds the expected response of each request until it completes.
module tb_master_port;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_mode = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mode;
  logic          wr_bus;
  logic          master_valid;
  logic          master_ready;
  logic          rd_bus = 1'b0;
  logic          slave_ready = 1'b0;
  logic          slave_valid = 1'b0;

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid), .master_ready(master_ready),
    .rd_bus(rd_bus), .slave_ready(slave_ready), .slave_valid(slave_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. The slave model optionally stalls the write side for stall_len
  // cycles at bit index stall_at, and returns rd_nbits of rd_val after rd_delay idle cycles.
  task automatic run_txn(input string name, input logic m, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int stall_at, input int stall_len,
                         input bit sr_en, input int rd_delay, input int rd_nbits,
                         input logic [DW-1:0] rd_val, input int exp_lat);
    exp_t e;
    logic [AW+DW-1:0] got = '0;
    int   cyc = 1;
    int   nw = 0, stalled = 0, rd_wait = 0, rd_sent = 0;
    bit   bus_ok = 1'b1, saw_mready = 1'b0;
    e.err   = !sr_en || (!m && rd_nbits < DW);
    e.rdata = (m || e.err) ? '0 : rd_val;
    e.lat   = exp_lat;
    sb.push_back(e);

    check({name, " req_ready idle"}, req_ready, 1);
    req_valid = 1'b1; req_mode = m; req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0;
    while (!rsp_valid && cyc < 400) begin
      slave_ready = sr_en && !(stall_at >= 0 && nw == stall_at && stalled < stall_len);
      if (master_valid && sr_en && !slave_ready) stalled++;
      if (master_valid && mode !== m) bus_ok = 1'b0;
      if (master_valid && master_ready) bus_ok = 1'b0;
      if (master_ready && mode !== 1'b0) bus_ok = 1'b0;
      if (master_valid && slave_ready) begin
        got = {got[AW+DW-2:0], wr_bus};
        nw++;
      end
      slave_valid = 1'b0;
      if (master_ready) begin
        saw_mready = 1'b1;
        if (rd_wait < rd_delay) rd_wait++;
        else if (rd_sent < rd_nbits) begin
          slave_valid = 1'b1;
          rd_bus      = rd_val[DW-1-rd_sent];
          rd_sent++;
        end
      end
      step();
      cyc++;
    end
    slave_ready = 1'b0; slave_valid = 1'b0; rd_bus = 1'b0;

    check({name, " rsp_valid seen"}, rsp_valid, 1);
    if (rsp_valid) begin
      e = sb.pop_front();
      check({name, " latency"}, cyc, e.lat);
      check({name, " rsp_err"}, rsp_err, e.err);
      check({name, " rsp_rdata"}, rsp_rdata, e.rdata);
      check({name, " bus idle in rsp"}, {mode, wr_bus, master_valid, master_ready}, 0);
      check({name, " bus protocol"}, bus_ok, 1);
      check({name, " bits sent"}, nw, !sr_en ? 0 : (m ? AW + DW : AW));
      if (sr_en && m)  check({name, " write stream"}, got, {addr, wd});
      if (sr_en && !m) check({name, " addr stream"}, got[AW-1:0], addr);
      if (!m)          check({name, " master_ready seen"}, saw_mready, 1);
      step();
      check({name, " rsp pulse one cycle"}, rsp_valid, 0);
      check({name, " req_ready after rsp"}, req_ready, 1);
      check({name, " rdata held"}, rsp_rdata, e.rdata);
    end
  endtask

  initial begin
    #3;
    check("reset req_ready", req_ready, 1);
    check("reset outputs", {rsp_valid, rsp_rdata, rsp_err, mode, wr_bus, master_valid, master_ready}, 0);
    step();
    rst = 1'b0;
    step();

    run_txn("wr25", 1'b1, 16'h0025, 8'hA5, -1, 0, 1'b1, 0, 0, 8'h00, AW + DW + 1);
    run_txn("rd03", 1'b0, 16'h0003, 8'h00, -1, 0, 1'b1, 3, DW, 8'h3C, AW + 3 + DW + 1);
    run_txn("wrstall", 1'b1, 16'h0025, 8'hA5, 7, 5, 1'b1, 0, 0, 8'h00, AW + DW + 1 + 5);
    run_txn("timeout", 1'b1, 16'h1234, 8'h5A, -1, 0, 1'b0, 0, 0, 8'h00, TO);
    run_txn("rdshort", 1'b0, 16'h00F0, 8'h00, -1, 0, 1'b1, 3, 4, 8'hC3, AW + 3 + 4 + TO);
    run_txn("rdimm", 1'b0, 16'hFFFF, 8'h00, -1, 0, 1'b1, 0, DW, 8'hFF, AW + DW + 1);

    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            dly;
      a   = AW'($urandom);
      d   = DW'($urandom);
      dly = int'($urandom_range(0, 5));
      run_txn($sformatf("rndwr%0d", i), 1'b1, a, d, -1, 0, 1'b1, 0, 0, 8'h00, AW + DW + 1);
      run_txn($sformatf("rndrd%0d", i), 1'b0, a, 8'h00, -1, 0, 1'b1, dly, DW, d, AW + dly + DW + 1);
    end

    // Reset in the middle of the data phase of a write.
    req_valid = 1'b1; req_mode = 1'b1; req_addr = 16'hBEEF; req_wdata = 8'h81;
    step();
    req_valid   = 1'b0;
    slave_ready = 1'b1;
    repeat (AW + 2) step();
    check("pre-reset in data phase", {master_valid, mode}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("reset bus outputs", {mode, wr_bus, master_valid, master_ready, rsp_valid}, 0);
    check("reset req_ready", req_ready, 1);
    slave_ready = 1'b0;
    step();
    rst = 1'b0;
    begin
      bit spurious = 1'b0;
      repeat (30) begin
        step();
        if (rsp_valid || !req_ready) spurious = 1'b1;
      end
      check("no rsp after reset", spurious, 0);
    end
    check("scoreboard empty", sb.size(), 0);
    run_txn("postrst", 1'b1, 16'h8001, 8'h7E, -1, 0, 1'b1, 0, 0, 8'h00, AW + DW + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
